hls_mul_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one 16x16 signed multiplier instance among NUM_REQ requesters in the HLS datapath. The multiplier is combinational and produces the low 16 bits of the signed product. This block owns operand muxing, a two-stage valid/ready pipeline around the multiplier, and tagged result return. It sits between the HLS compute kernels and the single instantiated multiplier, saving DSP48 slices.

---
 rtl/hls_mul_share_arb.sv | 105 ++++++++++
 tb/tb_hls_mul_share_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_mul_share_arb.sv
// Round-robin arbiter sharing one external 16x16 signed multiplier among NUM_REQ
// requesters, with a two-stage valid/ready pipeline and tagged result return.
module hls_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [15:0]           mul_a,
    output logic [15:0]           mul_b,
    input  logic [15:0]           mul_p,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [15:0]           resp_p,
    output logic                  busy,
    output logic [31:0]           ops_done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic              s1_valid;
    logic [ID_W-1:0]   s1_id;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  nxt_ptr;
    logic              found;
    logic              hs;
    logic              adv1;
    logic              adv2;
    logic [15:0]       a_arr [NUM_REQ];
    logic [15:0]       b_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[16*g +: 16];
        assign b_arr[g] = req_b[16*g +: 16];
    end

    assign adv2 = !resp_valid || resp_ready;
    assign adv1 = !s1_valid || adv2;
    assign busy = s1_valid || resp_valid;

    // Search starts at rr_ptr and wraps; first valid requester wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign hs      = found && adv1 && ap_rst_n;
    assign nxt_ptr = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        req_ready = '0;
        if (hs)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            rr_ptr     <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_p     <= '0;
            ops_done   <= '0;
        end else begin
            if (adv1) begin
                if (hs) begin
                    s1_valid <= 1'b1;
                    s1_id    <= ID_W'(win);
                    mul_a    <= a_arr[win];
                    mul_b    <= b_arr[win];
                    rr_ptr   <= nxt_ptr;
                end else begin
                    s1_valid <= 1'b0;
                end
            end
            if (adv2) begin
                resp_valid <= s1_valid;
                if (s1_valid) begin
                    resp_p  <= mul_p;
                    resp_id <= s1_id;
                end
            end
            if (resp_valid && resp_ready)
                ops_done <= ops_done + 32'd1;
        end
    end

endmodule

// File: tb/tb_hls_mul_share_arb.sv
// Directed bench for hls_mul_share_arb: table of single ops plus hand-written
// fairness, backpressure, pointer and mid-operation reset sequences.
module tb_hls_mul_share_arb;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_p;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [15:0] resp_p;
    logic        busy;
    logic [31:0] ops_done;

    int errors = 0;
    int checks = 0;
    int unsigned exp_ops = 0;

    always #5 ap_clk = ~ap_clk;

    // External shared multiplier: low 16 bits of the signed product.
    assign mul_p = 16'($signed(mul_a) * $signed(mul_b));

    hls_mul_share_arb #(.NUM_REQ(4), .ID_W(2)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    typedef struct {
        int unsigned id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_op(input int unsigned i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic do_reset();
        ap_rst_n  = 1'b0;
        req_valid = 4'h0;
        tick();
        ap_rst_n  = 1'b1;
        exp_ops   = 0;
    endtask

    task automatic do_single(input int unsigned id, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] p);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        resp_ready = 1'b1;
        set_op(id, a, b);
        req_valid = oh;
        #1;
        chk("single_req_ready", 32'(req_ready), 32'(oh));
        tick();
        chk("single_mul_a", 32'(mul_a), 32'(a));
        chk("single_mul_b", 32'(mul_b), 32'(b));
        chk("single_latency_rv0", 32'(resp_valid), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        req_valid = 4'h0;
        tick();
        chk("single_resp_valid", 32'(resp_valid), 32'd1);
        chk("single_resp_id", 32'(resp_id), id);
        chk("single_resp_p", 32'(resp_p), 32'(p));
        tick();
        exp_ops++;
        chk("single_ops_done", ops_done, exp_ops);
        chk("single_rv_clear", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{id: 2, a: 16'h0003, b: 16'hFFFE, p: 16'hFFFA};
        vecs[1] = '{id: 0, a: 16'h7FFF, b: 16'h0002, p: 16'hFFFE};
        vecs[2] = '{id: 1, a: 16'hFFFF, b: 16'hFFFF, p: 16'h0001};
        vecs[3] = '{id: 3, a: 16'h0100, b: 16'h0100, p: 16'h0000};
        vecs[4] = '{id: 0, a: 16'h8000, b: 16'hFFFF, p: 16'h8000};
        vecs[5] = '{id: 3, a: 16'h1234, b: 16'h0010, p: 16'h2340};

        ap_rst_n   = 1'b0;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        req_a      = 64'h0004_0003_0002_0001;
        req_b      = 64'h0010_0010_0010_0010;

        // Reset held 3 cycles with every requester asking.
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_ops_done", ops_done, 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = 4'h0;
        ap_rst_n  = 1'b1;
        tick();

        for (int v = 0; v < 6; v++)
            do_single(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].p);

        // Fairness: all valid for 8 grants, rr_ptr starts at 0 after reset.
        do_reset();
        for (int i = 0; i < 4; i++)
            set_op(i, 16'(i + 1), 16'h0010);
        resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8)
                chk("fair_grant", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            if (c >= 2) begin
                chk("fair_resp_valid", 32'(resp_valid), 32'd1);
                chk("fair_resp_id", 32'(resp_id), 32'((c - 2) % 4));
                chk("fair_resp_p", 32'(resp_p), 32'((((c - 2) % 4) + 1) * 16));
            end
            tick();
        end
        chk("fair_ops_done", ops_done, 32'd8);
        exp_ops = 8;

        // Backpressure: two ops fill both stages, then no grant.
        resp_ready = 1'b0;
        set_op(0, 16'h0005, 16'h0003);
        req_valid = 4'b0001;
        #1;
        chk("bp_grant0", 32'(req_ready), 32'd1);
        tick();
        set_op(0, 16'h0007, 16'h0003);
        #1;
        chk("bp_grant1", 32'(req_ready), 32'd1);
        tick();
        set_op(0, 16'h0009, 16'h0003);
        #1;
        chk("bp_full_ready", 32'(req_ready), 32'd0);
        chk("bp_resp_p", 32'(resp_p), 32'h000F);
        chk("bp_resp_id", 32'(resp_id), 32'd0);
        tick();
        chk("bp_hold_ready", 32'(req_ready), 32'd0);
        chk("bp_hold_p", 32'(resp_p), 32'h000F);
        chk("bp_hold_valid", 32'(resp_valid), 32'd1);
        chk("bp_hold_mul_a", 32'(mul_a), 32'h0007);
        req_valid  = 4'h0;
        resp_ready = 1'b1;
        tick();
        chk("bp_drain2_valid", 32'(resp_valid), 32'd1);
        chk("bp_drain2_p", 32'(resp_p), 32'h0015);
        tick();
        chk("bp_drain_done", 32'(resp_valid), 32'd0);
        exp_ops += 2;
        chk("bp_ops_done", ops_done, exp_ops);

        // Pointer: one op from requester 1 leaves rr_ptr at 2.
        do_single(1, 16'h0002, 16'h0002, 16'h0004);
        set_op(3, 16'h0002, 16'h0003);
        set_op(1, 16'h0004, 16'h0005);
        req_valid = 4'b1010;
        #1;
        chk("ptr_first", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b0010;
        #1;
        chk("ptr_second", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'hF;
        #1;
        chk("ptr_after", 32'(req_ready), 32'b0100);
        chk("ptr_resp_id0", 32'(resp_id), 32'd3);
        chk("ptr_resp_p0", 32'(resp_p), 32'h0006);
        req_valid = 4'h0;
        tick();
        chk("ptr_resp_id1", 32'(resp_id), 32'd1);
        chk("ptr_resp_p1", 32'(resp_p), 32'h0014);
        tick();
        exp_ops += 2;
        chk("ptr_ops_done", ops_done, exp_ops);

        // Mid-operation reset drops both in-flight ops.
        resp_ready = 1'b0;
        set_op(0, 16'h0003, 16'h0003);
        req_valid = 4'b0001;
        tick();
        set_op(0, 16'h0004, 16'h0003);
        tick();
        req_valid = 4'h0;
        #1;
        chk("midrst_busy_before", 32'(busy), 32'd1);
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        ap_rst_n   = 1'b1;
        resp_ready = 1'b1;
        chk("midrst_ops_done", ops_done, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
